// File: rtl/window_gen.sv
// rtl/window_gen.sv - 3x3 sliding-window generator over a raster pixel stream.
// Two line buffers plus a 3x3 register window; one window per interior pixel.
module window_gen #(
    parameter int DATA_BW = 8,
    parameter int IMG_W   = 16,
    parameter int IMG_H   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_dxi_in_valid,
    input  logic [DATA_BW-1:0]   i_dxi_in_data,
    output logic                 o_dxi_in_ready,
    output logic                 o_dxi_out_valid,
    output logic [DATA_BW*9-1:0] o_dxi_out_data,
    input  logic                 i_dxi_out_ready,
    output logic                 o_frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0] c;
    logic [RW-1:0] r;

    logic [DATA_BW-1:0] lb0 [IMG_W];
    logic [DATA_BW-1:0] lb1 [IMG_W];
    logic [DATA_BW-1:0] win     [3][3];
    logic [DATA_BW-1:0] win_nxt [3][3];
    logic [DATA_BW*9-1:0] win_pack;

    logic accept;
    logic col_last;
    logic row_last;
    logic emit;

    // Single output register: accept whenever that register is free or draining.
    assign o_dxi_in_ready = i_rstn && (!o_dxi_out_valid || i_dxi_out_ready);
    assign accept         = i_dxi_in_valid && o_dxi_in_ready;
    assign col_last       = (c == CW'(IMG_W - 1));
    assign row_last       = (r == RW'(IMG_H - 1));
    // Column gate keeps windows from straddling rows; row gate hides stale frame data.
    assign emit           = accept && (r >= RW'(2)) && (c >= CW'(2));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            win_nxt[i][0] = win[i][1];
            win_nxt[i][1] = win[i][2];
        end
        win_nxt[0][2] = lb1[c];
        win_nxt[1][2] = lb0[c];
        win_nxt[2][2] = i_dxi_in_data;
    end

    // Top-left lands in the MSB slice, bottom-right (newest pixel) in the LSB slice.
    always_comb begin
        win_pack = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_pack[DATA_BW*(8-(3*i+j)) +: DATA_BW] = win_nxt[i][j];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            win     <= win_nxt;
            lb1[c]  <= lb0[c];
            lb0[c]  <= i_dxi_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_dxi_out_valid <= 1'b0;
            o_dxi_out_data  <= '0;
            o_frame_done    <= 1'b0;
            r               <= '0;
            c               <= '0;
        end else begin
            o_frame_done <= accept && col_last && row_last;
            if (emit) begin
                o_dxi_out_data  <= win_pack;
                o_dxi_out_valid <= 1'b1;
            end else if (i_dxi_out_ready) begin
                o_dxi_out_valid <= 1'b0;
            end
            if (accept) begin
                if (col_last) begin
                    c <= '0;
                    r <= row_last ? '0 : r + RW'(1);
                end else begin
                    c <= c + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window_gen.sv
// tb/tb_window_gen.sv - randomized self-checking bench for window_gen (4x4 and 16x16 instances).
module tb_window_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        a_valid, a_iready, a_ovalid, a_ordy, a_fdone;
    logic [7:0]  a_data;
    logic [71:0] a_odata;
    logic        b_valid, b_iready, b_ovalid, b_ordy, b_fdone;
    logic [7:0]  b_data;
    logic [71:0] b_odata;

    always #5 clk = ~clk;

    window_gen #(.DATA_BW(8), .IMG_W(4), .IMG_H(4)) u_small (
        .i_clk(clk), .i_rstn(rstn),
        .i_dxi_in_valid(a_valid), .i_dxi_in_data(a_data), .o_dxi_in_ready(a_iready),
        .o_dxi_out_valid(a_ovalid), .o_dxi_out_data(a_odata), .i_dxi_out_ready(a_ordy),
        .o_frame_done(a_fdone)
    );

    window_gen #(.DATA_BW(8), .IMG_W(16), .IMG_H(16)) u_wide (
        .i_clk(clk), .i_rstn(rstn),
        .i_dxi_in_valid(b_valid), .i_dxi_in_data(b_data), .o_dxi_in_ready(b_iready),
        .o_dxi_out_valid(b_ovalid), .o_dxi_out_data(b_odata), .i_dxi_out_ready(b_ordy),
        .o_frame_done(b_fdone)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          sel = 0;
    int          mw = 4, mh = 4, mr = 0, mc = 0;
    logic        exp_valid = 1'b0;
    logic        exp_fd = 1'b0;
    logic [7:0]  img [16][16];
    logic [71:0] q [$];
    int          win_cnt = 0;
    int          fd_cnt = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] model_win(input int rr, input int cc);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], img[rr-2+i][cc-2+j]};
        return w;
    endfunction

    // Window of the 4x4 test image whose pixel values are off + 4*row + col + 1.
    function automatic logic [71:0] basic_win(input int rr, input int cc, input int off);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], 8'(off + 4*(rr+i) + (cc+j) + 1)};
        return w;
    endfunction

    // One clock: drive at negedge, check settled outputs, advance the reference model.
    task automatic step(input logic v, input logic [7:0] d, input logic rdy,
                        input logic rst_n, output logic acc);
        logic ov, ir, fd, m_rdy, produced;
        logic [71:0] od;
        rstn    = rst_n;
        a_valid = (sel == 0) && v;
        a_data  = d;
        a_ordy  = (sel == 0) ? rdy : 1'b1;
        b_valid = (sel == 1) && v;
        b_data  = d;
        b_ordy  = (sel == 1) ? rdy : 1'b1;
        #1;
        ov = (sel == 0) ? a_ovalid : b_ovalid;
        ir = (sel == 0) ? a_iready : b_iready;
        fd = (sel == 0) ? a_fdone  : b_fdone;
        od = (sel == 0) ? a_odata  : b_odata;
        m_rdy = rst_n && (!exp_valid || rdy);
        check("out_valid", 72'(ov), 72'(exp_valid));
        check("frame_done", 72'(fd), 72'(exp_fd));
        check("in_ready", 72'(ir), 72'(m_rdy));
        if (exp_valid && ov) begin
            if (q.size() == 0) check("window_queue", 72'(1), 72'(0));
            else               check("window", od, q[0]);
        end
        acc = v && m_rdy;
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_fd    = 1'b0;
            mr = 0;
            mc = 0;
            q.delete();
        end else begin
            if (exp_valid && rdy && q.size() > 0) begin
                void'(q.pop_front());
                win_cnt++;
            end
            produced = acc && mr >= 2 && mc >= 2;
            if (acc) img[mr][mc] = d;
            if (produced) q.push_back(model_win(mr, mc));
            exp_valid = produced || (exp_valid && !rdy);
            exp_fd    = acc && mr == mh-1 && mc == mw-1;
            if (exp_fd) fd_cnt++;
            if (acc) begin
                if (mc == mw-1) begin
                    mc = 0;
                    mr = (mr == mh-1) ? 0 : mr + 1;
                end else begin
                    mc++;
                end
            end
        end
        @(negedge clk);
    endtask

    // base < 0 sends random pixels; otherwise pixel k of the frame is base + k + 1.
    task automatic send_frame(input int base, input int vprob, input int rprob, output int cycles);
        int idx = 0;
        logic acc;
        logic v, rdy;
        logic [7:0] d;
        cycles = 0;
        while (idx < mw*mh && cycles < 20000) begin
            v   = ($urandom_range(99) < vprob);
            rdy = ($urandom_range(99) < rprob);
            d   = (base >= 0) ? 8'(base + idx + 1) : 8'($urandom);
            step(v, d, rdy, 1'b1, acc);
            if (acc) idx++;
            cycles++;
        end
        if (idx < mw*mh) check("send_timeout", 72'(idx), 72'(mw*mh));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1, acc);
    endtask

    initial begin
        int   cyc;
        logic acc;
        rstn = 1'b0;
        a_valid = 1'b0; a_data = '0; a_ordy = 1'b1;
        b_valid = 1'b0; b_data = '0; b_ordy = 1'b1;
        @(negedge clk);
        step(1'b1, 8'h00, 1'b1, 1'b0, acc);
        step(1'b1, 8'h00, 1'b1, 1'b0, acc);
        check("reset_data", a_odata, 72'(0));
        check("reset_valid", 72'(a_ovalid), 72'(0));

        // basic frame
        win_cnt = 0; fd_cnt = 0;
        send_frame(0, 100, 100, cyc);
        drain();
        check("basic_windows", 72'(win_cnt), 72'(4));
        check("basic_frame_done", 72'(fd_cnt), 72'(1));

        // backpressure on the first window
        win_cnt = 0;
        for (int k = 1; k <= 11; k++) step(1'b1, 8'(k), 1'b1, 1'b1, acc);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 8'd12, 1'b0, 1'b1, acc);
            check("bp_hold_data", a_odata, basic_win(0, 0, 0));
            check("bp_no_accept", 72'(acc), 72'(0));
        end
        step(1'b1, 8'd12, 1'b1, 1'b1, acc);
        check("bp_release_accept", 72'(acc), 72'(1));
        for (int k = 13; k <= 16; k++) step(1'b1, 8'(k), 1'b1, 1'b1, acc);
        drain();
        check("bp_windows", 72'(win_cnt), 72'(4));

        // gapped input
        win_cnt = 0;
        send_frame(0, 50, 100, cyc);
        drain();
        check("gap_windows", 72'(win_cnt), 72'(4));

        // back-to-back frames
        win_cnt = 0; fd_cnt = 0;
        send_frame(0, 100, 100, cyc);
        send_frame(100, 100, 100, cyc);
        check("b2b_second_first", q.size() > 0 ? q[0] : 72'(0), basic_win(1, 1, 100));
        drain();
        check("b2b_windows", 72'(win_cnt), 72'(8));
        check("b2b_frame_done", 72'(fd_cnt), 72'(2));

        // reset with a window pending
        for (int k = 1; k <= 11; k++) step(1'b1, 8'(k), 1'b1, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        step(1'b0, 8'h00, 1'b0, 1'b0, acc);
        check("rst_mid_valid", 72'(a_ovalid), 72'(0));
        win_cnt = 0;
        send_frame(0, 100, 100, cyc);
        drain();
        check("rst_mid_windows", 72'(win_cnt), 72'(4));

        // random data with random gaps and backpressure
        win_cnt = 0;
        for (int f = 0; f < 3; f++) send_frame(-1, 60, 60, cyc);
        drain();
        check("rand_windows", 72'(win_cnt), 72'(12));

        // wide image at full throughput
        sel = 1; mw = 16; mh = 16; mr = 0; mc = 0;
        win_cnt = 0; fd_cnt = 0;
        send_frame(-1, 100, 100, cyc);
        check("wide_cycles", 72'(cyc), 72'(256));
        drain();
        check("wide_windows", 72'(win_cnt), 72'(196));
        check("wide_frame_done", 72'(fd_cnt), 72'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
